// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM states, counter sizing and named polynomials for the serial CRC encoder
package crc_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH} state_t;
  localparam logic [15:0] CRC16_IBM = 16'h8005;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [7:0] CRC8_ATM = 8'h07;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/crc_step.sv
// crc_step: one-bit MSB-first LFSR update for a normal-form generator polynomial
module crc_step import crc_pkg::*; #(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(CRC16_IBM)
) (
  input logic [CRC_W-1:0] crc_in,
  input logic data_bit,
  output logic [CRC_W-1:0] crc_out
);
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ ((crc_in[CRC_W-1] ^ data_bit) ? POLY : '0);
endmodule

// File: rtl/crc_serial_gen.sv
// crc_serial_gen: parametrised bit-serial CRC encoder; define CRC_CHECK_EN to add the received-codeword residue check
module crc_serial_gen import crc_pkg::*; #(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(CRC16_IBM),
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic in_valid,
  input logic in_bit,
  input logic in_last,
`ifdef CRC_CHECK_EN
  input logic check_mode,
  output logic crc_ok,
`endif
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic busy,
  output logic done,
  output logic [CRC_W-1:0] crc_value
);
  localparam int CW = cnt_w(CRC_W);
  state_t state, state_n;
  logic [CRC_W-1:0] crc_reg, crc_n, next_crc, val_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ov_n, ob_n, ol_n, dn_n, chk;
  crc_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
    .crc_in(crc_reg),
    .data_bit(in_bit),
    .crc_out(next_crc)
  );
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    crc_n = crc_reg;
    cnt_n = cnt;
    ov_n = 1'b0;
    ob_n = 1'b0;
    ol_n = 1'b0;
    dn_n = out_last;
    val_n = crc_value;
    case (state)
      IDLE: begin
        crc_n = INIT;
        state_n = start ? COMPUTE : IDLE;
      end
      COMPUTE: begin
        if (start) begin
          crc_n = INIT;
        end else if (in_valid) begin
          crc_n = next_crc;
          ov_n = 1'b1;
          ob_n = in_bit;
          if (in_last && chk) begin
            crc_n = INIT;
            val_n = next_crc;
            dn_n = 1'b1;
            state_n = IDLE;
          end else if (in_last) begin
            crc_n = next_crc ^ XOROUT;
            val_n = next_crc ^ XOROUT;
            cnt_n = '0;
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        ov_n = 1'b1;
        ob_n = crc_reg[CRC_W-1];
        crc_n = {crc_reg[CRC_W-2:0], 1'b0};
        cnt_n = cnt + 1'b1;
        ol_n = cnt == CW'(CRC_W - 1);
        state_n = ol_n ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      crc_reg <= INIT;
      cnt <= '0;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
      done <= 1'b0;
      crc_value <= '0;
    end else begin
      state <= state_n;
      crc_reg <= crc_n;
      cnt <= cnt_n;
      out_valid <= ov_n;
      out_bit <= ob_n;
      out_last <= ol_n;
      done <= dn_n;
      crc_value <= val_n;
    end
  end
`ifdef CRC_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk <= 1'b0;
      crc_ok <= 1'b0;
    end else begin
      if (state == IDLE && start) chk <= check_mode;
      if (state == COMPUTE && !start && in_valid && in_last && chk) crc_ok <= next_crc == '0;
    end
  end
`else
  assign chk = 1'b0;
`endif
endmodule

// File: tb/tb_crc_serial_gen.sv
// tb_crc_serial_gen: directed checks of crc_serial_gen across four parameter sets (plus residue check when CRC_CHECK_EN is defined)
module tb_crc_serial_gen;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0;
  logic [3:0] ov, ob, ol, bz, dn;
  logic [15:0] c16, cc, cc0;
  logic [7:0] c8;
`ifdef CRC_CHECK_EN
  logic check_mode = 1'b0;
  logic [3:0] ok;
`endif
  int total = 0, bad = 0, ngaps = 0;
  logic [71:0] msg = "123456789";
  logic [87:0] ref88;
  always #5 clk = ~clk;
  crc_serial_gen d16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .check_mode(check_mode), .crc_ok(ok[0]),
`endif
    .out_valid(ov[0]), .out_bit(ob[0]), .out_last(ol[0]), .busy(bz[0]), .done(dn[0]), .crc_value(c16)
  );
  crc_serial_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) dc (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .check_mode(check_mode), .crc_ok(ok[1]),
`endif
    .out_valid(ov[1]), .out_bit(ob[1]), .out_last(ol[1]), .busy(bz[1]), .done(dn[1]), .crc_value(cc)
  );
  crc_serial_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) dc0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .check_mode(check_mode), .crc_ok(ok[2]),
`endif
    .out_valid(ov[2]), .out_bit(ob[2]), .out_last(ol[2]), .busy(bz[2]), .done(dn[2]), .crc_value(cc0)
  );
  crc_serial_gen #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00)) d8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .check_mode(check_mode), .crc_ok(ok[3]),
`endif
    .out_valid(ov[3]), .out_bit(ob[3]), .out_last(ol[3]), .busy(bz[3]), .done(dn[3]), .crc_value(c8)
  );
  logic rec_clr = 1'b0;
  logic [127:0] sbits;
  int n16, last_idx, last_cyc, done_cyc, ndone, cyc, n8, lo8;
  bit on8, end8;
  always @(negedge clk) begin
    if (rec_clr) begin
      n16 <= 0; last_idx <= -1; last_cyc <= -1; done_cyc <= -9; ndone <= 0;
      cyc <= 0; n8 <= 0; lo8 <= 0; on8 <= 1'b0; end8 <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (ol[0]) begin
        last_idx <= n16;
        last_cyc <= cyc;
      end
      if (ov[0]) begin
        if (n16 < 128) sbits[n16] <= ob[0];
        n16 <= n16 + 1;
      end
      if (dn[0]) begin
        done_cyc <= cyc;
        ndone <= ndone + 1;
      end
      if (ov[3]) begin
        n8 <= n8 + 1;
        on8 <= 1'b1;
      end else if (on8 && !end8) begin
        lo8 <= lo8 + 1;
      end
      if (ol[3]) end8 <= 1'b1;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    rec_clr = 1'b1;
    tick();
    tick();
    rec_clr = 1'b0;
  endtask
  task automatic pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [127:0] data, input int n, input bit gaps, input bit fin);
    ngaps = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i % 9 == 4) begin
        in_valid = 1'b0;
        in_last = 1'b1;
        ngaps++;
        tick();
      end
      in_valid = 1'b1;
      in_bit = data[n-1-i];
      in_last = fin && i == n - 1;
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_bit = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (dn[0] !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    chk("done_seen", {31'd0, dn[0]}, 32'd1);
  endtask
  initial begin
    int sb;
    ref88 = {msg, 16'hFEE8};
    tick();
    tick();
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_out_bit", {31'd0, ob[0]}, 32'd0);
    chk("rst_out_last", {31'd0, ol[0]}, 32'd0);
    chk("rst_done", {31'd0, dn[0]}, 32'd0);
    chk("rst_busy", {31'd0, bz[0]}, 32'd0);
    chk("rst_crc16", {16'd0, c16}, 32'd0);
    chk("rst_crc8", {24'd0, c8}, 32'd0);
    rst = 1'b1;
    tick();
    clr();
    pulse();
    send({56'd0, msg}, 72, 1'b0, 1'b1);
    chk("busy_flush", {31'd0, bz[0]}, 32'd1);
    wait_done();
    tick();
    tick();
    chk("ibm", {16'd0, c16}, 32'hFEE8);
    chk("ccitt_ffff", {16'd0, cc}, 32'h29B1);
    chk("ccitt_0", {16'd0, cc0}, 32'h31C3);
    chk("crc8", {24'd0, c8}, 32'hF4);
    chk("stream_len", n16, 88);
    chk("last_idx", last_idx, 87);
    chk("done_after_last", done_cyc - last_cyc, 1);
    sb = 0;
    for (int i = 0; i < 88; i++) if (sbits[i] !== ref88[87-i]) sb++;
    chk("stream_bits", sb, 0);
    chk("done_count", ndone, 1);
    chk("crc8_valid_cnt", n8, 80);
    chk("crc8_no_gap", lo8, 0);
    chk("idle_busy", {31'd0, bz[0]}, 32'd0);
    clr();
    pulse();
    send({56'd0, msg}, 72, 1'b1, 1'b1);
    wait_done();
    tick();
    tick();
    chk("gap_ibm", {16'd0, c16}, 32'hFEE8);
    chk("gap_ccitt_ffff", {16'd0, cc}, 32'h29B1);
    chk("gap_ccitt_0", {16'd0, cc0}, 32'h31C3);
    chk("gap_crc8", {24'd0, c8}, 32'hF4);
    chk("gap_crc8_valid_cnt", n8, 80);
    chk("gap_crc8_low_cnt", lo8, ngaps);
    chk("gap_done_count", ndone, 1);
    clr();
    pulse();
    send(128'h1, 1, 1'b0, 1'b1);
    wait_done();
    tick();
    tick();
    chk("one_ibm", {16'd0, c16}, 32'h8005);
    chk("one_ccitt_ffff", {16'd0, cc}, 32'hFFFE);
    chk("one_ccitt_0", {16'd0, cc0}, 32'h1021);
    chk("one_crc8", {24'd0, c8}, 32'h07);
    chk("one_stream_len", n16, 17);
    chk("one_last_idx", last_idx, 16);
    clr();
    pulse();
    send({56'd0, msg}, 20, 1'b0, 1'b0);
    start = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    chk("abort_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("abort_busy", {31'd0, bz[0]}, 32'd1);
    send({56'd0, msg}, 72, 1'b0, 1'b1);
    wait_done();
    tick();
    tick();
    chk("abort_ibm", {16'd0, c16}, 32'hFEE8);
    chk("abort_crc8", {24'd0, c8}, 32'hF4);
    chk("abort_done_count", ndone, 1);
    pulse();
    send({56'd0, msg}, 72, 1'b0, 1'b1);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("flushrst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("flushrst_crc16", {16'd0, c16}, 32'd0);
    chk("flushrst_busy", {31'd0, bz[0]}, 32'd0);
    chk("flushrst_crc8", {24'd0, c8}, 32'd0);
    rst = 1'b1;
    tick();
    clr();
    pulse();
    send({56'd0, msg}, 72, 1'b0, 1'b1);
    wait_done();
    tick();
    tick();
    chk("clean_ibm", {16'd0, c16}, 32'hFEE8);
    chk("clean_done_count", ndone, 1);
`ifdef CRC_CHECK_EN
    check_mode = 1'b1;
    pulse();
    check_mode = 1'b0;
    send({40'd0, ref88}, 88, 1'b0, 1'b1);
    wait_done();
    chk("chk_ok", {31'd0, ok[0]}, 32'd1);
    chk("chk_residue", {16'd0, c16}, 32'd0);
    tick();
    check_mode = 1'b1;
    pulse();
    check_mode = 1'b0;
    send({40'd0, ref88 ^ 88'h8}, 88, 1'b0, 1'b1);
    wait_done();
    chk("chk_bad_ok", {31'd0, ok[0]}, 32'd0);
    tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
